prefetch_ar_arbiter: RTL and testbench

// Shares one downstream AXI read port (AR + R) between NUM_REQ prefetcher instances.

---
 rtl/prefetch_ar_arbiter_pkg.sv | 27 ++
 rtl/prefetch_ar_arbiter_if.sv | 52 +++++
 rtl/prefetch_ar_arbiter_rr_arbiter.sv | 31 +++
 rtl/prefetch_ar_arbiter.sv | 155 +++++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_ar_arbiter_pkg.sv
// rtl/prefetch_ar_arbiter_pkg.sv - width helpers and ID tag pack/unpack for the AR arbiter
package prefetch_arb_pkg;

  // Wide carrier for tagged IDs so the pack/unpack helpers stay width-agnostic.
  typedef logic [63:0] tag_bus_t;

  function automatic int idx_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(int max_out);
    return $clog2(max_out + 1);
  endfunction

  // Place the requester index above the requester-side ID bits.
  function automatic tag_bus_t pack_tag(int unsigned idx, int unsigned tid_w, tag_bus_t id);
    return (tag_bus_t'(idx) << tid_w) | id;
  endfunction

  // Recover the requester index from a tagged ID.
  function automatic int unsigned unpack_tag(tag_bus_t id, int unsigned tid_w);
    tag_bus_t sh;
    sh = id >> tid_w;
    return sh[31:0];
  endfunction

endpackage

// File: rtl/prefetch_ar_arbiter_if.sv
// rtl/prefetch_ar_arbiter_if.sv - requester-side and downstream AXI read signals of the arbiter
// master: arbiter view (drives s_ar_ready, m_ar_*, m_r_ready, s_r_*).
// slave : surrounding view (prefetchers and DDR controller).
interface prefetch_ar_arbiter_if #(
  parameter int NUM_REQ              = 4,
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6
);
  import prefetch_arb_pkg::*;

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int M_TID_W = IDX_W + TID_WIDTH;
  localparam int DATA_W  = 8 << LOG_BLOCK_DATA_BYTES;

  logic [NUM_REQ-1:0]                 s_ar_valid;
  logic [NUM_REQ-1:0]                 s_ar_ready;
  logic [NUM_REQ*ADDR_BITS-1:0]       s_ar_addr;
  logic [NUM_REQ*BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [NUM_REQ*TID_WIDTH-1:0]       s_ar_id;
  logic                               m_ar_valid;
  logic                               m_ar_ready;
  logic [ADDR_BITS-1:0]               m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0]         m_ar_len;
  logic [M_TID_W-1:0]                 m_ar_id;
  logic                               m_r_valid;
  logic                               m_r_ready;
  logic                               m_r_last;
  logic [DATA_W-1:0]                  m_r_data;
  logic [M_TID_W-1:0]                 m_r_id;
  logic [NUM_REQ-1:0]                 s_r_valid;
  logic [NUM_REQ-1:0]                 s_r_ready;
  logic                               s_r_last;
  logic [DATA_W-1:0]                  s_r_data;
  logic [TID_WIDTH-1:0]               s_r_id;

  modport master (
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, m_ar_ready,
    input  m_r_valid, m_r_last, m_r_data, m_r_id, s_r_ready,
    output s_ar_ready, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    output m_r_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );

  modport slave (
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, m_ar_ready,
    output m_r_valid, m_r_last, m_r_data, m_r_id, s_r_ready,
    input  s_ar_ready, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    input  m_r_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );

endinterface

// File: rtl/prefetch_ar_arbiter_rr_arbiter.sv
// rtl/prefetch_ar_arbiter_rr_arbiter.sv - combinational round-robin one-hot grant
// Ports: req (requests), ptr (highest-priority index, < N), grant (one-hot or zero).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;
  int   pos;

  // Scan N positions starting at ptr; inner loop keeps every select constant-indexed.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!found && pos == i && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// rtl/prefetch_ar_arbiter.sv - shares one AXI read port between NUM_REQ prefetchers
// Ports: clk, reset (async, active-high), bus (requester AR/R + downstream AR/R),
//        idle (no AR held, no bursts in flight), err_badid (sticky bad-tag / credit underflow).
module prefetch_ar_arbiter
  import prefetch_arb_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int MAX_OUTSTANDING      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  prefetch_ar_arbiter_if.master bus,
  output logic                  idle,
  output logic                  err_badid
);

  localparam int IDX_W   = idx_w(NUM_REQ);
  localparam int M_TID_W = IDX_W + TID_WIDTH;
  localparam int CNT_W   = cnt_w(MAX_OUTSTANDING);
  localparam int DATA_W  = 8 << LOG_BLOCK_DATA_BYTES;

  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          err_q, err_d;
  logic                          m_ar_valid_q;
  logic [ADDR_BITS-1:0]          m_ar_addr_q;
  logic [BURST_LEN_WIDTH-1:0]    m_ar_len_q;
  logic [M_TID_W-1:0]            m_ar_id_q;

  logic [NUM_REQ-1:0]         eligible, grant, ar_hs;
  logic                       load_en, any_hs;
  logic [IDX_W-1:0]           gidx;
  logic [ADDR_BITS-1:0]       sel_addr;
  logic [BURST_LEN_WIDTH-1:0] sel_len;
  logic [TID_WIDTH-1:0]       sel_id;
  tag_bus_t                   packed_id;
  int unsigned                r_tag;
  logic                       tag_ok, r_hs, r_hs_last, dec;
  logic [NUM_REQ-1:0]         r_valid_route;
  logic                       r_ready_route;
  logic [DATA_W-1:0]          r_data_w;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.s_ar_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Register can take a new burst when empty or being drained this cycle.
  assign load_en        = ~m_ar_valid_q | bus.m_ar_ready;
  assign ar_hs          = load_en ? grant : '0;
  assign any_hs         = |ar_hs;
  assign bus.s_ar_ready = ar_hs;

  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_len  = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx     = IDX_W'(i);
        sel_addr = bus.s_ar_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_len  = bus.s_ar_len[i*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        sel_id   = bus.s_ar_id[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  assign packed_id = pack_tag(int'(gidx), TID_WIDTH, tag_bus_t'(sel_id));
  assign ptr_d     = !any_hs ? ptr_q :
                     (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);

  // R demux: an out-of-range tag has no owner, so the beat is sunk here.
  assign r_tag  = unpack_tag(tag_bus_t'(bus.m_r_id), TID_WIDTH);
  assign tag_ok = r_tag < unsigned'(NUM_REQ);

  always_comb begin
    r_valid_route = '0;
    r_ready_route = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_tag == unsigned'(i)) begin
        r_valid_route[i] = bus.m_r_valid;
        r_ready_route    = bus.s_r_ready[i];
      end
    end
  end

  assign r_hs      = bus.m_r_valid & r_ready_route;
  assign r_hs_last = r_hs & bus.m_r_last;

  // Credit counters: accept and completion in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (r_hs & ~tag_ok);
    dec   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec = r_hs_last && (r_tag == unsigned'(i));
      if (ar_hs[i] && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !ar_hs[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      m_ar_valid_q <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
      m_ar_id_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (any_hs) begin
        m_ar_valid_q <= 1'b1;
        m_ar_addr_q  <= sel_addr;
        m_ar_len_q   <= sel_len;
        m_ar_id_q    <= M_TID_W'(packed_id);
      end else if (bus.m_ar_ready) begin
        m_ar_valid_q <= 1'b0;
      end
    end
  end

  assign bus.m_ar_valid = m_ar_valid_q;
  assign bus.m_ar_addr  = m_ar_addr_q;
  assign bus.m_ar_len   = m_ar_len_q;
  assign bus.m_ar_id    = m_ar_id_q;
  assign bus.m_r_ready  = r_ready_route;
  assign bus.s_r_valid  = r_valid_route;
  assign bus.s_r_last   = bus.m_r_last;
  assign r_data_w       = bus.m_r_data;
  assign bus.s_r_data   = r_data_w;
  assign bus.s_r_id     = bus.m_r_id[TID_WIDTH-1:0];
  assign idle           = ~m_ar_valid_q && (cnt_q == '0);
  assign err_badid      = err_q;

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// tb/tb_prefetch_ar_arbiter.sv - self-checking bench for prefetch_ar_arbiter
module tb_prefetch_ar_arbiter;
  localparam int NR = 4, AB = 16, LB = 8, TW = 8, LD = 2, MO = 2, NRB = 3;
  localparam int MTW = 2 + TW, DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic idle_a, err_a, idle_b, err_b;

  prefetch_ar_arbiter_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .BURST_LEN_WIDTH(LB),
    .TID_WIDTH(TW), .LOG_BLOCK_DATA_BYTES(LD)) bus_a ();
  prefetch_ar_arbiter_if #(.NUM_REQ(NRB), .ADDR_BITS(AB), .BURST_LEN_WIDTH(LB),
    .TID_WIDTH(TW), .LOG_BLOCK_DATA_BYTES(LD)) bus_b ();

  prefetch_ar_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .BURST_LEN_WIDTH(LB),
    .TID_WIDTH(TW), .LOG_BLOCK_DATA_BYTES(LD), .MAX_OUTSTANDING(MO)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.master), .idle(idle_a), .err_badid(err_a));

  prefetch_ar_arbiter #(.NUM_REQ(NRB), .ADDR_BITS(AB), .BURST_LEN_WIDTH(LB),
    .TID_WIDTH(TW), .LOG_BLOCK_DATA_BYTES(LD), .MAX_OUTSTANDING(MO)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.master), .idle(idle_b), .err_badid(err_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AB-1:0]  addr;
    logic [LB-1:0]  len;
    logic [MTW-1:0] id;
  } ar_t;

  ar_t exp_q[$];
  ar_t mon_e;

  function automatic ar_t mk(int i);
    ar_t e;
    e.addr = AB'(32'h1000 + i);
    e.len  = LB'(i + 1);
    e.id   = {2'(i), 8'(32'h10 + i)};
    return e;
  endfunction

  // Scoreboard: every downstream AR handshake pops the oldest expected burst.
  always @(negedge clk) begin
    #4;
    if (!rst_a && bus_a.m_ar_valid && bus_a.m_ar_ready) begin
      if (exp_q.size() == 0) begin
        chk("ar_unexpected", 64'(bus_a.m_ar_id), 64'h3ff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ar_addr", 64'(bus_a.m_ar_addr), 64'(mon_e.addr));
        chk("ar_len",  64'(bus_a.m_ar_len),  64'(mon_e.len));
        chk("ar_id",   64'(bus_a.m_ar_id),   64'(mon_e.id));
      end
    end
  end

  task automatic defaults_a();
    bus_a.s_ar_valid = '0;
    bus_a.m_ar_ready = 1'b1;
    bus_a.m_r_valid  = 1'b0;
    bus_a.m_r_last   = 1'b0;
    bus_a.m_r_id     = '0;
    bus_a.m_r_data   = '0;
    bus_a.s_r_ready  = '0;
    for (int i = 0; i < NR; i++) begin
      bus_a.s_ar_addr[i*AB +: AB] = AB'(32'h1000 + i);
      bus_a.s_ar_len[i*LB +: LB]  = LB'(i + 1);
      bus_a.s_ar_id[i*TW +: TW]   = TW'(32'h10 + i);
    end
  endtask

  task automatic defaults_b();
    bus_b.s_ar_valid = '0;
    bus_b.s_ar_addr  = '0;
    bus_b.s_ar_len   = '0;
    bus_b.s_ar_id    = '0;
    bus_b.m_ar_ready = 1'b1;
    bus_b.m_r_valid  = 1'b0;
    bus_b.m_r_last   = 1'b0;
    bus_b.m_r_id     = '0;
    bus_b.m_r_data   = '0;
    bus_b.s_r_ready  = '0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    defaults_a();
    exp_q.delete();
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk("ar_drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic           vld;
    logic [MTW-1:0] id;
    logic [NR-1:0]  rdy;
    logic [DW-1:0]  data;
    logic [NR-1:0]  e_sv;
    logic           e_mr;
    logic [TW-1:0]  e_sid;
  } rvec_t;

  rvec_t tbl[6];
  int    order[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, {2'd0, 8'hAA}, 4'b0001, 32'h0000_1111, 4'b0001, 1'b1, 8'hAA};
    tbl[1] = '{1'b1, {2'd1, 8'hBB}, 4'b0001, 32'h2222_3333, 4'b0010, 1'b0, 8'hBB};
    tbl[2] = '{1'b1, {2'd2, 8'hCC}, 4'b0100, 32'h4444_5555, 4'b0100, 1'b1, 8'hCC};
    tbl[3] = '{1'b0, {2'd3, 8'hDD}, 4'b1111, 32'h6666_7777, 4'b0000, 1'b1, 8'hDD};
    tbl[4] = '{1'b1, {2'd3, 8'hEE}, 4'b0111, 32'h8888_9999, 4'b1000, 1'b0, 8'hEE};
    tbl[5] = '{1'b0, {2'd1, 8'h11}, 4'b0000, 32'hAAAA_BBBB, 4'b0000, 1'b0, 8'h11};
    order = '{1, 2, 3, 0};
    defaults_a();
    defaults_b();

    // Reset values while reset is held.
    @(negedge clk);
    #1;
    chk("rst_m_ar_valid", 64'(bus_a.m_ar_valid), 64'd0);
    chk("rst_m_ar_addr",  64'(bus_a.m_ar_addr),  64'd0);
    chk("rst_m_ar_len",   64'(bus_a.m_ar_len),   64'd0);
    chk("rst_m_ar_id",    64'(bus_a.m_ar_id),    64'd0);
    chk("rst_idle",       64'(idle_a),           64'd1);
    chk("rst_err",        64'(err_a),            64'd0);
    chk("rst_s_ar_ready", 64'(bus_a.s_ar_ready), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;

    // req0 and req2 granted on consecutive cycles.
    @(negedge clk);
    bus_a.s_ar_valid = 4'b0101;
    exp_q.push_back(mk(0));
    #1 chk("basic_grant0", 64'(bus_a.s_ar_ready), 64'b0001);
    @(negedge clk);
    bus_a.s_ar_valid = 4'b0100;
    exp_q.push_back(mk(2));
    #1 chk("basic_grant2", 64'(bus_a.s_ar_ready), 64'b0100);
    @(negedge clk);
    bus_a.s_ar_valid = '0;
    #1 chk("basic_not_idle", 64'(idle_a), 64'd0);
    drain();

    // Backpressure with all requesters valid.
    reset_a();
    @(negedge clk);
    bus_a.m_ar_ready = 1'b0;
    bus_a.s_ar_valid = 4'b1111;
    exp_q.push_back(mk(0));
    #1 chk("bp_first", 64'(bus_a.s_ar_ready), 64'b0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_ready_low", 64'(bus_a.s_ar_ready), 64'd0);
      chk("bp_valid",     64'(bus_a.m_ar_valid), 64'd1);
      chk("bp_addr_hold", 64'(bus_a.m_ar_addr),  64'h1000);
      chk("bp_id_hold",   64'(bus_a.m_ar_id),    64'(mk(0).id));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_a.m_ar_ready = 1'b1;
      exp_q.push_back(mk(order[k]));
      #1 chk("bp_rr_order", 64'(bus_a.s_ar_ready), 64'(1 << order[k]));
    end
    @(negedge clk);
    bus_a.s_ar_valid = '0;
    drain();

    // Credit cap of 2 on req1, released by one R last.
    reset_a();
    @(negedge clk);
    bus_a.s_ar_valid = 4'b0010;
    exp_q.push_back(mk(1));
    #1 chk("cap_first", 64'(bus_a.s_ar_ready), 64'b0010);
    @(negedge clk);
    exp_q.push_back(mk(1));
    #1 chk("cap_second", 64'(bus_a.s_ar_ready), 64'b0010);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk("cap_blocked", 64'(bus_a.s_ar_ready), 64'd0);
    end
    @(negedge clk);
    bus_a.m_r_valid = 1'b1;
    bus_a.m_r_id    = {2'd1, 8'h21};
    bus_a.m_r_last  = 1'b1;
    bus_a.s_r_ready = 4'b0010;
    #1;
    chk("cap_r_ready",   64'(bus_a.m_r_ready),  64'd1);
    chk("cap_r_valid",   64'(bus_a.s_r_valid),  64'b0010);
    chk("cap_still_blk", 64'(bus_a.s_ar_ready), 64'd0);
    @(negedge clk);
    bus_a.m_r_valid = 1'b0;
    bus_a.m_r_last  = 1'b0;
    exp_q.push_back(mk(1));
    #1 chk("cap_released", 64'(bus_a.s_ar_ready), 64'b0010);
    @(negedge clk);
    bus_a.s_ar_valid = '0;
    drain();

    // R demux to requester 3 with backpressure; decrement only on last.
    reset_a();
    @(negedge clk);
    bus_a.s_ar_valid = 4'b1000;
    exp_q.push_back(mk(3));
    #1 chk("dmx_ar", 64'(bus_a.s_ar_ready), 64'b1000);
    @(negedge clk);
    bus_a.s_ar_valid = '0;
    bus_a.m_r_valid  = 1'b1;
    bus_a.m_r_id     = {2'd3, 8'h5A};
    bus_a.s_r_ready  = '0;
    #1;
    chk("dmx_s_r_valid", 64'(bus_a.s_r_valid), 64'b1000);
    chk("dmx_m_r_ready", 64'(bus_a.m_r_ready), 64'd0);
    chk("dmx_s_r_id",    64'(bus_a.s_r_id),    64'h5A);
    @(negedge clk);
    bus_a.s_r_ready = 4'b1000;
    #1 chk("dmx_m_r_ready_hs", 64'(bus_a.m_r_ready), 64'd1);
    @(negedge clk);
    bus_a.m_r_last = 1'b1;
    #1 chk("dmx_not_last_idle", 64'(idle_a), 64'd0);
    @(negedge clk);
    bus_a.m_r_valid = 1'b0;
    bus_a.m_r_last  = 1'b0;
    #1;
    chk("dmx_last_idle", 64'(idle_a), 64'd1);
    chk("dmx_err",       64'(err_a),  64'd0);
    drain();

    // Same-cycle AR accept and R last for req0 at count 1.
    reset_a();
    @(negedge clk);
    bus_a.s_ar_valid = 4'b0001;
    exp_q.push_back(mk(0));
    #1 chk("sc_first", 64'(bus_a.s_ar_ready), 64'b0001);
    @(negedge clk);
    bus_a.m_r_valid = 1'b1;
    bus_a.m_r_id    = {2'd0, 8'h01};
    bus_a.m_r_last  = 1'b1;
    bus_a.s_r_ready = 4'b0001;
    exp_q.push_back(mk(0));
    #1 chk("sc_both", 64'(bus_a.s_ar_ready), 64'b0001);
    @(negedge clk);
    bus_a.m_r_valid = 1'b0;
    bus_a.m_r_last  = 1'b0;
    exp_q.push_back(mk(0));
    #1 chk("sc_cnt_one", 64'(bus_a.s_ar_ready), 64'b0001);
    @(negedge clk);
    #1;
    chk("sc_cnt_full", 64'(bus_a.s_ar_ready), 64'd0);
    chk("sc_err",      64'(err_a),            64'd0);
    bus_a.s_ar_valid = '0;
    drain();

    // Table of R routing vectors (non-last beats only).
    reset_a();
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      bus_a.m_r_valid = tbl[v].vld;
      bus_a.m_r_id    = tbl[v].id;
      bus_a.s_r_ready = tbl[v].rdy;
      bus_a.m_r_data  = tbl[v].data;
      #1;
      chk("tbl_s_r_valid", 64'(bus_a.s_r_valid), 64'(tbl[v].e_sv));
      chk("tbl_m_r_ready", 64'(bus_a.m_r_ready), 64'(tbl[v].e_mr));
      chk("tbl_s_r_id",    64'(bus_a.s_r_id),    64'(tbl[v].e_sid));
      chk("tbl_s_r_data",  64'(bus_a.s_r_data),  64'(tbl[v].data));
    end
    @(negedge clk);
    bus_a.m_r_valid = 1'b0;
    #1 chk("tbl_err", 64'(err_a), 64'd0);

    // Bad tag on the 3-requester instance.
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b_rst_err",  64'(err_b),  64'd0);
    chk("b_rst_idle", 64'(idle_b), 64'd1);
    @(negedge clk);
    bus_b.m_r_valid = 1'b1;
    bus_b.m_r_id    = {2'd3, 8'h77};
    bus_b.s_r_ready = 3'b111;
    #1;
    chk("bad_m_r_ready", 64'(bus_b.m_r_ready), 64'd1);
    chk("bad_s_r_valid", 64'(bus_b.s_r_valid), 64'd0);
    chk("bad_err_pre",   64'(err_b),           64'd0);
    @(negedge clk);
    bus_b.m_r_valid = 1'b0;
    #1 chk("bad_err_set", 64'(err_b), 64'd1);
    repeat (3) @(negedge clk);
    bus_b.m_r_valid = 1'b1;
    bus_b.m_r_id    = {2'd2, 8'h33};
    bus_b.s_r_ready = 3'b000;
    #1;
    chk("bad_err_sticky", 64'(err_b),           64'd1);
    chk("b_tag2_valid",   64'(bus_b.s_r_valid), 64'b100);
    chk("b_tag2_ready",   64'(bus_b.m_r_ready), 64'd0);
    @(negedge clk);
    bus_b.m_r_valid = 1'b0;
    rst_b = 1'b1;
    #1 chk("b_err_cleared", 64'(err_b), 64'd0);
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.m_r_valid = 1'b1;
    bus_b.m_r_id    = {2'd0, 8'h01};
    bus_b.m_r_last  = 1'b1;
    bus_b.s_r_ready = 3'b001;
    #1 chk("under_err_pre", 64'(err_b), 64'd0);
    @(negedge clk);
    bus_b.m_r_valid = 1'b0;
    bus_b.m_r_last  = 1'b0;
    #1 chk("under_err_set", 64'(err_b), 64'd1);

    // Async reset between clock edges while an AR is held.
    reset_a();
    @(negedge clk);
    bus_a.m_ar_ready = 1'b0;
    bus_a.s_ar_valid = 4'b0100;
    @(negedge clk);
    bus_a.s_ar_valid = '0;
    #1 chk("ar_held", 64'(bus_a.m_ar_valid), 64'd1);
    #2 rst_a = 1'b1;
    #1;
    chk("async_valid", 64'(bus_a.m_ar_valid), 64'd0);
    chk("async_addr",  64'(bus_a.m_ar_addr),  64'd0);
    chk("async_id",    64'(bus_a.m_ar_id),    64'd0);
    chk("async_idle",  64'(idle_a),           64'd1);
    @(negedge clk);
    rst_a = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
